// File: rtl/count_game_ctrl.sv
// Count-game sequencer: countdown, BCD hit scoring and beeper start/hold handshake.
// Optional macro COUNT_GAME_PAUSE_EN: a start press during RUN toggles a pause.
module count_game_ctrl #(
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned GAME_SEC  = 30,
  parameter int unsigned ALARM_TMO = 2000
) (
  input  logic       clk,
  input  logic       st,
  input  logic       btn_start,
  input  logic       btn_hit,
  input  logic       beep_over,
  output logic       beep_st,
  output logic [7:0] sec_bcd,
  output logic [7:0] score_bcd,
  output logic [1:0] state,
  output logic       running
);

  localparam int unsigned TMO_W = (ALARM_TMO > 1) ? $clog2(ALARM_TMO) : 1;
  localparam logic [15:0]      TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(ALARM_TMO - 1);
  localparam logic [7:0]       SEC_INIT  = {4'(GAME_SEC / 10), 4'(GAME_SEC % 10)};

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_ALARM = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t           r_state;
  logic             r_beep;
  logic [7:0]       r_sec;
  logic [7:0]       r_score;
  logic             r_running;
  logic [15:0]      r_tick;
  logic [TMO_W-1:0] r_timer;
  logic             r_prevStart;
  logic             r_prevHit;

  logic       w_startP;
  logic       w_hitP;
  logic       w_tickWrap;
  logic       w_active;
  logic [7:0] w_secNext;

  function automatic logic [7:0] bcdDec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Saturates at 99 so a long game never wraps the displayed score.
  function automatic logic [7:0] bcdInc(input logic [7:0] v);
    if (v == 8'h99) return v;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign w_startP   = btn_start & ~r_prevStart;
  assign w_hitP     = btn_hit & ~r_prevHit;
  assign w_tickWrap = (r_tick == TICK_LAST);
  assign w_secNext  = bcdDec(r_sec);

`ifdef COUNT_GAME_PAUSE_EN
  logic r_pause;
  assign w_active = ~r_pause;
`else
  assign w_active = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!st) begin
      r_state     <= S_IDLE;
      r_beep      <= 1'b0;
      r_sec       <= SEC_INIT;
      r_score     <= 8'h00;
      r_running   <= 1'b0;
      r_tick      <= '0;
      r_timer     <= '0;
      r_prevStart <= 1'b1;
      r_prevHit   <= 1'b1;
`ifdef COUNT_GAME_PAUSE_EN
      r_pause     <= 1'b0;
`endif
    end else begin
      r_prevStart <= btn_start;
      r_prevHit   <= btn_hit;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_startP) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
            r_sec     <= SEC_INIT;
            r_score   <= 8'h00;
            r_tick    <= '0;
            r_timer   <= '0;
`ifdef COUNT_GAME_PAUSE_EN
            r_pause   <= 1'b0;
`endif
          end
        end
        S_RUN: begin
`ifdef COUNT_GAME_PAUSE_EN
          if (w_startP) begin
            r_pause   <= ~r_pause;
            r_running <= r_pause;
          end
`endif
          // Leaving RUN below overrides the pause toggle above.
          if (w_active) begin
            if (w_hitP) r_score <= bcdInc(r_score);
            if (w_tickWrap) begin
              r_tick <= '0;
              r_sec  <= w_secNext;
              if (w_secNext == 8'h00) begin
                r_state   <= S_ALARM;
                r_beep    <= 1'b1;
                r_running <= 1'b0;
`ifdef COUNT_GAME_PAUSE_EN
                r_pause   <= 1'b0;
`endif
              end
            end else begin
              r_tick <= r_tick + 16'd1;
            end
          end
        end
        S_ALARM: begin
          if (beep_over || (r_timer == TMO_LAST)) begin
            r_state <= S_DONE;
            r_beep  <= 1'b0;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign state     = r_state;
  assign beep_st   = r_beep;
  assign sec_bcd   = r_sec;
  assign score_bcd = r_score;
  assign running   = r_running;

endmodule

// File: tb/tb_count_game_ctrl.sv
// Scoreboard bench for count_game_ctrl: two instances (short game and a 12 s game
// that reaches score saturation) share stimulus and are checked against a cycle-count model.
module tb_count_game_ctrl;

  logic       clk;
  logic       st;
  logic       btnStart;
  logic       btnHit;
  logic       beepOver;

  logic       aBeep, bBeep;
  logic [7:0] aSec, bSec, aScore, bScore;
  logic [1:0] aState, bState;
  logic       aRun, bRun;

  typedef struct packed {
    logic [1:0] state;
    logic       beep;
    logic [7:0] sec;
    logic [7:0] score;
    logic       running;
  } obs_t;

  // Game modes: 0 idle, 1 run, 2 alarm, 3 done. remain = RUN cycles still to play.
  typedef struct {
    int mode;
    int remain;
    int secs;
    int score;
    int alarm;
    bit prevS;
    bit prevH;
    bit paused;
  } model_t;

`ifdef COUNT_GAME_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  obs_t   qA[$];
  obs_t   qB[$];
  model_t mA, mB;
  int     checks = 0;
  int     errors = 0;
  int     cycle  = 0;

  count_game_ctrl #(.TICK_DIV(4), .GAME_SEC(3), .ALARM_TMO(10)) dutA (
    .clk(clk), .st(st), .btn_start(btnStart), .btn_hit(btnHit), .beep_over(beepOver),
    .beep_st(aBeep), .sec_bcd(aSec), .score_bcd(aScore), .state(aState), .running(aRun)
  );

  count_game_ctrl #(.TICK_DIV(60), .GAME_SEC(12), .ALARM_TMO(10)) dutB (
    .clk(clk), .st(st), .btn_start(btnStart), .btn_hit(btnHit), .beep_over(beepOver),
    .beep_st(bBeep), .sec_bcd(bSec), .score_bcd(bScore), .state(bState), .running(bRun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic model_t modelStep(input model_t m, input int tdiv, input int gsec,
                                       input int tmo, input bit rstN, input bit s,
                                       input bit h, input bit o);
    model_t n;
    bit sp, hp;
    n = m;
    if (!rstN) begin
      n.mode = 0; n.remain = 0; n.secs = gsec; n.score = 0; n.alarm = 0;
      n.prevS = 1'b1; n.prevH = 1'b1; n.paused = 1'b0;
      return n;
    end
    sp = s && !m.prevS;
    hp = h && !m.prevH;
    n.prevS = s;
    n.prevH = h;
    case (m.mode)
      0, 3: begin
        if (sp) begin
          n.mode = 1; n.remain = gsec * tdiv; n.secs = gsec; n.score = 0; n.paused = 1'b0;
        end
      end
      1: begin
        if (PAUSE_EN && sp) n.paused = !m.paused;
        if (!m.paused) begin
          if (hp && m.score < 99) n.score = m.score + 1;
          n.remain = m.remain - 1;
          n.secs = (n.remain + tdiv - 1) / tdiv;
          if (n.remain == 0) begin
            n.mode = 2; n.alarm = 0; n.paused = 1'b0;
          end
        end
      end
      default: begin
        if (o || m.alarm == tmo - 1) begin
          n.mode = 3; n.alarm = 0;
        end else begin
          n.alarm = m.alarm + 1;
        end
      end
    endcase
    return n;
  endfunction

  function automatic obs_t expOf(input model_t m);
    obs_t e;
    e.state   = 2'(m.mode);
    e.beep    = (m.mode == 2);
    e.sec     = {4'(m.secs / 10), 4'(m.secs % 10)};
    e.score   = {4'(m.score / 10), 4'(m.score % 10)};
    e.running = (m.mode == 1) && !m.paused;
    return e;
  endfunction

  // Inputs change on the falling edge; the model predicts the state after the next rising edge.
  task automatic applyStimulus(input bit rstN, input bit s, input bit h, input bit o);
    @(negedge clk);
    st = rstN; btnStart = s; btnHit = h; beepOver = o;
    mA = modelStep(mA, 4, 3, 10, rstN, s, h, o);
    mB = modelStep(mB, 60, 12, 10, rstN, s, h, o);
    qA.push_back(expOf(mA));
    qB.push_back(expOf(mB));
  endtask

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got state=%0d beep=%0d sec=%h score=%h run=%0d, expected state=%0d beep=%0d sec=%h score=%h run=%0d",
               name, cycle, act.state, act.beep, act.sec, act.score, act.running,
               exp.state, exp.beep, exp.sec, exp.score, exp.running);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pressStart();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pressHit();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic waitModeA(input int target, input int budget);
    int n;
    n = 0;
    while (mA.mode != target && n < budget) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end
    checks++;
    if (mA.mode != target) begin
      errors++;
      $display("[TB] FAIL waitModeA: mode=%0d after %0d cycles, required %0d", mA.mode, n, target);
    end
  endtask

  // Monitor: one observation per rising edge, compared against the queued prediction.
  initial begin
    obs_t actA, actB;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (qA.size() > 0) begin
        actA.state = aState; actA.beep = aBeep; actA.sec = aSec;
        actA.score = aScore; actA.running = aRun;
        checkOutput("dutA", actA, qA.pop_front());
      end
      if (qB.size() > 0) begin
        actB.state = bState; actB.beep = bBeep; actB.sec = bSec;
        actB.score = bScore; actB.running = bRun;
        checkOutput("dutB", actB, qB.pop_front());
      end
    end
  end

  initial begin
    st = 1'b0; btnStart = 1'b0; btnHit = 1'b0; beepOver = 1'b0;
    mA = '{0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0};
    mB = mA;

    // Reset, then a start that coincides with a hit: start wins.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    idle(12);
    idle(14);

    // Scoring from DONE, then a long held hit.
    pressStart();
    repeat (12) pressHit();
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Beeper handshake on the third ALARM cycle.
    pressStart();
    waitModeA(2, 40);
    idle(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // ALARM timeout with beep_over low.
    pressStart();
    waitModeA(2, 40);
    idle(12);

    // Reset mid-RUN with start held through reset release.
    pressStart();
    repeat (3) pressHit();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Hit on the final tick cycle, then restart from DONE.
    pressStart();
    idle(10);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    idle(13);
    pressStart();
    idle(3);

    // Score saturation on the long game.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    pressStart();
    repeat (101) pressHit();
    idle(2);

    // Start during RUN (pause toggle when the feature is built).
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    pressStart();
    idle(3);
    pressStart();
    idle(8);
    pressStart();
    idle(20);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(63) != 0), ($urandom_range(11) == 0),
                    ($urandom_range(1) == 1), ($urandom_range(5) == 0));
    end

    @(posedge clk);
    #3;
    checks++;
    if (qA.size() != 0 || qB.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: queues hold %0d/%0d entries, required 0/0", qA.size(), qB.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
